// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave (MSB first) exposing a 2^ADDR_W byte
// register bank. Every SPI input is oversampled in the clk domain, so
// sck must run at clk/8 or slower.
//
// Frame: a command byte {rw, ..., addr[ADDR_W-1:0]} followed by data bytes.
// Byte 0 of the bank is the read-only ID_VALUE. Writes to byte 0 are dropped.
//
// Optional feature macro: SPI_REG_AUTOINC_EN
//   defined   - burst mode. The address increments after every data byte.
//   undefined - a single data byte per frame. Later bytes are ignored.
module spi_reg_slave #(
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sck,
  input  logic                          ss_n,
  input  logic                          sdi,
  output logic                          sdo,
  output logic [8*(2**ADDR_W)-1:0]      regs_o,
  output logic                          wr_stb,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [7:0]                    wr_data
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  // Synchronizer chains. The third stage on sck and ss_n is for edge detection.
  logic [2:0] sck_sync_reg;
  logic [2:0] ss_sync_reg;
  logic [1:0] sdi_sync_reg;

  logic sck_rise, sck_fall, ss_rise, ss_level, sdi_bit;

  // Frame datapath
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_in_reg;
  logic [7:0]        shift_out_reg;
  logic              rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              sdo_reg;

  // A completed write waits here for one clk before it reaches the bank.
  logic              wr_pend_reg;
  logic [ADDR_W-1:0] pend_addr_reg;
  logic [7:0]        pend_data_reg;

  logic              wr_stb_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;

  logic [7:0] bank_reg [DEPTH];

  logic              byte_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rw;
  logic [7:0]        cmd_rd_byte;
`ifdef SPI_REG_AUTOINC_EN
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        next_rd_byte;
`endif

  // Bring the asynchronous SPI pins into the clk domain. ss_n resets to
  // "selected" so that ARM has to see a real deselect before accepting a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_reg <= 3'b000;
      ss_sync_reg  <= 3'b000;
      sdi_sync_reg <= 2'b00;
    end else begin
      sck_sync_reg <= {sck_sync_reg[1:0], sck};
      ss_sync_reg  <= {ss_sync_reg[1:0], ss_n};
      sdi_sync_reg <= {sdi_sync_reg[0], sdi};
    end
  end

  assign sck_rise = sck_sync_reg[1] & ~sck_sync_reg[2];
  assign sck_fall = ~sck_sync_reg[1] & sck_sync_reg[2];
  assign ss_rise  = ss_sync_reg[1] & ~ss_sync_reg[2];
  assign ss_level = ss_sync_reg[1];
  assign sdi_bit  = sdi_sync_reg[1];

  // The byte as it will look after the current sample is shifted in.
  assign byte_done   = sck_rise && (bit_cnt_reg == 3'd7);
  assign rx_byte     = {shift_in_reg[6:0], sdi_bit};
  assign cmd_rw      = rx_byte[7];
  assign cmd_addr    = rx_byte[ADDR_W-1:0];
  assign cmd_rd_byte = bank_reg[cmd_addr];
`ifdef SPI_REG_AUTOINC_EN
  assign addr_next    = addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign next_rd_byte = bank_reg[addr_next];
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_ARM;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic. A deselect aborts any frame in progress.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ARM: begin
        if (ss_level) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!ss_level) state_next = ST_CMD;
      end
      ST_CMD: begin
        if (ss_rise)        state_next = ST_IDLE;
        else if (byte_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (ss_rise) begin
          state_next = ST_IDLE;
        end else if (byte_done) begin
`ifdef SPI_REG_AUTOINC_EN
          state_next = ST_DATA;
`else
          state_next = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        if (ss_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_ARM;
    endcase
  end

  // Shift registers, command latch, MISO driver and write hand-off.
  // bit_cnt counts sck rises within the current byte and wraps to 0 after 8.
  // A falling edge only advances MISO once the byte has seen at least one
  // rise. This keeps the MSB that was loaded at the byte boundary on the
  // line until the master samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg   <= 3'd0;
      shift_in_reg  <= 8'h00;
      shift_out_reg <= 8'h00;
      rw_reg        <= 1'b0;
      addr_reg      <= '0;
      sdo_reg       <= 1'b0;
      wr_pend_reg   <= 1'b0;
      pend_addr_reg <= '0;
      pend_data_reg <= 8'h00;
    end else begin
      wr_pend_reg <= 1'b0;
      case (state_reg)
        ST_CMD: begin
          if (ss_rise) begin
            bit_cnt_reg <= 3'd0;
            sdo_reg     <= 1'b0;
          end else if (sck_rise) begin
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            shift_in_reg <= rx_byte;
            if (byte_done) begin
              rw_reg   <= cmd_rw;
              addr_reg <= cmd_addr;
              if (cmd_rw) begin
                shift_out_reg <= cmd_rd_byte;
                sdo_reg       <= cmd_rd_byte[7];
              end else begin
                sdo_reg <= 1'b0;
              end
            end
          end
        end
        ST_DATA: begin
          if (ss_rise) begin
            bit_cnt_reg <= 3'd0;
            sdo_reg     <= 1'b0;
          end else if (sck_rise) begin
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            shift_in_reg <= rx_byte;
            if (byte_done) begin
              if (!rw_reg && (addr_reg != '0)) begin
                wr_pend_reg   <= 1'b1;
                pend_addr_reg <= addr_reg;
                pend_data_reg <= rx_byte;
              end
`ifdef SPI_REG_AUTOINC_EN
              addr_reg <= addr_next;
              if (rw_reg) begin
                shift_out_reg <= next_rd_byte;
                sdo_reg       <= next_rd_byte[7];
              end
`else
              sdo_reg <= 1'b0;
`endif
            end
          end else if (sck_fall && rw_reg && (bit_cnt_reg != 3'd0)) begin
            sdo_reg       <= shift_out_reg[6];
            shift_out_reg <= {shift_out_reg[6:0], 1'b0};
          end
        end
        ST_DONE: begin
          sdo_reg <= 1'b0;
          if (ss_rise) bit_cnt_reg <= 3'd0;
        end
        default: begin
          // ARM and IDLE hold the line low and the bit counter at zero.
          bit_cnt_reg <= 3'd0;
          sdo_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe. It rises in the same cycle that the bank byte changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stb_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= 8'h00;
    end else begin
      wr_stb_reg <= wr_pend_reg;
      if (wr_pend_reg) begin
        wr_addr_reg <= pend_addr_reg;
        wr_data_reg <= pend_data_reg;
      end
    end
  end

  // Register bank. Byte 0 is a constant ID. Every other byte is a writable register.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
    if (gi == 0) begin : g_id
      // ID byte: never writable
      always_ff @(posedge clk) begin
        bank_reg[gi] <= ID_VALUE;
      end
    end else begin : g_rw
      // Writable byte: loaded from the pending write that targets it
      always_ff @(posedge clk) begin
        if (rst) begin
          bank_reg[gi] <= 8'h00;
        end else if (wr_pend_reg && (pend_addr_reg == ADDR_W'(gi))) begin
          bank_reg[gi] <= pend_data_reg;
        end
      end
    end
    assign regs_o[8*gi +: 8] = bank_reg[gi];
  end

  assign sdo     = sdo_reg;
  assign wr_stb  = wr_stb_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule
